// File: rtl/result_bcd_converter_pkg.sv
// Shared definitions for the result-register binary-to-BCD converter:
// FSM encoding, double-dabble constants and digit field offsets.
package result_bcd_converter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] BCD_CORR   = 4'd3;
    localparam logic [3:0] BCD_THRESH = 4'd5;

    // Bit offsets of each digit inside the packed bcd word.
    localparam int DIGIT_W     = 4;
    localparam int ONES_LSB    = 0;
    localparam int TENS_LSB    = 4;
    localparam int HUNDRED_LSB = 8;

endpackage

// File: rtl/result_bcd_converter_digit_adj.sv
// One BCD digit of the shift-and-add-3 correction: digits of 5 or more get
// +3 so that the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import result_bcd_converter_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= BCD_THRESH) ? din + BCD_CORR : din;

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter for the calculator result register:
// one input bit per clock, start/busy/done handshake, error flag carried along.
module result_bcd_converter
    import result_bcd_converter_pkg::*;
#(
    parameter int N      = 8,
    parameter int DIGITS = 3,
    parameter int CW     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [N-1:0]          bin,
    input  logic                  err_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  err_out
);

    localparam int SW = DIGIT_W * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    state_t          state, state_n;
    logic [N-1:0]    binreg;
    logic [SW-1:0]   scratch;
    logic [SW-1:0]   adj;
    logic [SW-1:0]   scratch_next;
    logic [CW-1:0]   cnt;
    logic            err_pend;
    logic            last;

    // blank[i] is set while digit i and every digit above it are zero.
    function automatic logic [DIGITS-1:0] blank_mask(input logic [SW-1:0] d);
        logic [DIGITS-1:0] m;
        logic              run;
        m   = '0;
        run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run  = run & (d[DIGIT_W*i +: DIGIT_W] == '0);
            m[i] = run;
        end
        return m;
    endfunction

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[DIGIT_W*g +: DIGIT_W]),
            .dout (adj[DIGIT_W*g +: DIGIT_W])
        );
    end

    assign scratch_next = {adj[SW-2:0], binreg[N-1]};
    assign last         = (state == SHIFT) && (cnt == CW'(1));
    assign busy         = (state == SHIFT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // NOTE: state_n gets a default before the case so no path infers a latch.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = SHIFT;
            SHIFT:   if (last)  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            binreg   <= '0;
            scratch  <= '0;
            cnt      <= '0;
            err_pend <= 1'b0;
            bcd      <= '0;
            blank    <= BLANK_RST;
            err_out  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    binreg   <= bin;
                    err_pend <= err_in;
                    scratch  <= '0;
                    cnt      <= CW'(N);
                end
            end else begin
                scratch <= scratch_next;
                binreg  <= {binreg[N-2:0], 1'b0};
                cnt     <= cnt - 1'b1;
                if (last) begin
                    bcd     <= scratch_next;
                    blank   <= blank_mask(scratch_next);
                    err_out <= err_pend;
                    done    <= 1'b1;
                end
            end
        end
    end

    // A finished digit above 9 means the correction network is broken.
    always @(posedge clk) begin
        if (!rst && last) begin
            for (int i = 0; i < DIGITS; i++) begin
                assert (scratch_next[DIGIT_W*i +: DIGIT_W] <= 4'd9)
                    else $error("bcd digit %0d out of range: %0d", i,
                                scratch_next[DIGIT_W*i +: DIGIT_W]);
            end
        end
    end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed bench for result_bcd_converter: latency, digit values, blanking,
// error flag capture, ignored starts, reset abort and back-to-back conversions.
module tb_result_bcd_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  bin;
    logic        err_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [2:0]  blank;
    logic        err_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    result_bcd_converter #(.N(8), .DIGITS(3), .CW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin     (bin),
        .err_in  (err_in),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd),
        .blank   (blank),
        .err_out (err_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_req(input logic [7:0] b, input logic e);
        start  = 1'b1;
        bin    = b;
        err_in = e;
        step();
        start  = 1'b0;
    endtask

    // Returns the number of cycles after acceptance until done is seen,
    // and how many of those sampled cycles had busy high.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && lat < 30) begin
            step();
            lat++;
            if (done !== 1'b1 && busy === 1'b1) busy_cnt++;
        end
        check("done_within_bound", 32'(done), 32'd1);
    endtask

    task automatic convert(input logic [7:0] b, input logic e,
                           input logic [11:0] exp_bcd, input logic [2:0] exp_blank,
                           input string tag);
        int lat, bc;
        start_req(b, e);
        wait_done(lat, bc);
        check({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
        check({tag, "_blank"}, 32'(blank), 32'(exp_blank));
    endtask

    initial begin
        int lat, bc, dones, t1, t2;
        logic [11:0] first_bcd;

        rst = 1'b1; start = 1'b0; bin = '0; err_in = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'h000);
        check("rst_blank", 32'(blank), 32'b110);
        check("rst_err_out", 32'(err_out), 32'd0);
        step();

        // 255: latency, busy width, all digits shown
        start_req(8'd255, 1'b0);
        wait_done(lat, bc);
        check("lat_255", 32'(lat), 32'd8);
        check("busy_cycles_255", 32'(bc), 32'd8);
        check("busy_in_done_cycle", 32'(busy), 32'd0);
        check("bcd_255", 32'(bcd), 32'h255);
        check("blank_255", 32'(blank), 32'b000);
        step();
        check("done_one_cycle", 32'(done), 32'd0);
        check("bcd_hold", 32'(bcd), 32'h255);

        convert(8'd0,   1'b0, 12'h000, 3'b110, "v0");
        convert(8'd7,   1'b0, 12'h007, 3'b110, "v7");
        convert(8'd100, 1'b0, 12'h100, 3'b000, "v100");
        convert(8'd58,  1'b0, 12'h058, 3'b100, "v58");
        step();

        // start while busy is ignored
        start_req(8'd42, 1'b0);
        step();
        start = 1'b1; bin = 8'd99;
        step();
        start = 1'b0; bin = 8'd0;
        dones = 0;
        first_bcd = '0;
        for (int i = 0; i < 25; i++) begin
            if (done === 1'b1) begin
                if (dones == 0) first_bcd = bcd;
                dones++;
            end
            step();
        end
        check("ignored_start_dones", 32'(dones), 32'd1);
        check("ignored_start_bcd", 32'(first_bcd), 32'h042);

        // err_in captured at acceptance only
        start_req(8'd200, 1'b1);
        err_in = 1'b0;
        wait_done(lat, bc);
        check("bcd_200", 32'(bcd), 32'h200);
        check("err_out_set", 32'(err_out), 32'd1);
        step();
        convert(8'd1, 1'b0, 12'h001, 3'b110, "v1");
        check("err_out_clear", 32'(err_out), 32'd0);
        step();

        // reset mid-conversion aborts without done
        start_req(8'd128, 1'b1);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_done", 32'(done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd), 32'h000);
        check("abort_blank", 32'(blank), 32'b110);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) dones++;
            step();
        end
        check("abort_no_done", 32'(dones), 32'd0);
        convert(8'd64, 1'b0, 12'h064, 3'b100, "v64");
        step();

        // start held through done: back-to-back conversions
        start = 1'b1; bin = 8'd10; err_in = 1'b0;
        step();
        bin = 8'd11;
        t1 = -1;
        t2 = -1;
        for (int i = 0; i < 30 && t2 < 0; i++) begin
            if (done === 1'b1) begin
                if (t1 < 0) begin
                    t1 = cyc;
                    check("b2b_first_bcd", 32'(bcd), 32'h010);
                end else begin
                    t2 = cyc;
                    check("b2b_second_bcd", 32'(bcd), 32'h011);
                end
            end
            if (t1 >= 0 && cyc > t1) start = 1'b0;
            step();
        end
        start = 1'b0;
        check("b2b_gap", 32'(t2 - t1), 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
